// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared jump-mode encodings and address typedef for the
//               program-counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [1:0] {
        JM_SEQ = 2'd0,
        JM_J   = 2'd1,
        JM_JR  = 2'd2,
        JM_JAL = 2'd3
    } jump_mode_t;

    localparam int INSTR_BYTES_DEF = 4;
    localparam int ADDR_W_DEF      = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack. When full, a push overwrites the
//               oldest entry and raises a one-cycle overflow pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int RAS_DEPTH = 8,
    parameter int ADDR_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [$clog2(RAS_DEPTH):0] count,
    output logic [ADDR_W-1:0]          top,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_entries [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              w_full;
    logic [PTR_W-1:0]  w_top_ptr;

    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
    assign w_top_ptr = r_wr_ptr - PTR_W'(1);

    // The write pointer wraps for free because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= push && w_full;
            if (push) begin
                r_entries[r_wr_ptr] <= push_data;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (pop && (r_count != '0)) begin
                r_wr_ptr <= w_top_ptr;
                r_count  <= r_count - CNT_W'(1);
            end
        end
    end

    assign count    = r_count;
    assign top      = (r_count == '0) ? '0 : r_entries[w_top_ptr];
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter register with next-PC selection, stall hold and
//               a return-address stack that checks jump-register returns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                RAS_DEPTH   = 8,
    parameter int                INSTR_BYTES = INSTR_BYTES_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [1:0]                 jump_mode,
    input  logic [ADDR_W-5:0]          fjump,
    input  logic [ADDR_W-1:0]          jumpreg,
    input  logic                       is_return,
    input  logic                       branch_taken,
    input  logic [ADDR_W-1:0]          branch_off,
    output logic [ADDR_W-1:0]          pc,
    output logic [ADDR_W-1:0]          pcadded,
    output logic [ADDR_W-1:0]          newdir,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic [ADDR_W-1:0]          ras_top,
    output logic                       ras_overflow,
    output logic                       ret_mismatch
);

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0] r_pc;
    logic              r_mismatch;
    logic [ADDR_W-1:0] w_pcadded;
    logic [ADDR_W-1:0] w_newdir;
    jump_mode_t        w_mode;
    logic              w_push;
    logic              w_pop_req;
    logic              w_ras_empty;
    logic [CNT_W-1:0]  w_ras_count;
    logic [ADDR_W-1:0] w_ras_top;

    assign w_mode    = jump_mode_t'(jump_mode);
    assign w_pcadded = r_pc + ADDR_W'(INSTR_BYTES);

    always_comb begin
        w_newdir = w_pcadded;
        if ((w_mode == JM_J) || (w_mode == JM_JAL)) begin
            w_newdir = {w_pcadded[ADDR_W-1:ADDR_W-4], fjump};
        end else if (w_mode == JM_JR) begin
            w_newdir = jumpreg;
        end else if (branch_taken) begin
            w_newdir = w_pcadded + branch_off;
        end
    end

    assign w_push      = !stall && (w_mode == JM_JAL);
    assign w_pop_req   = !stall && (w_mode == JM_JR) && is_return;
    assign w_ras_empty = (w_ras_count == '0);

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop_req),
        .push_data (w_pcadded),
        .count     (w_ras_count),
        .top       (w_ras_top),
        .overflow  (ras_overflow)
    );

    // The RAS only predicts; the PC always follows jumpreg on a return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_pop_req && (w_ras_empty || (w_ras_top != jumpreg));
            if (!stall) begin
                r_pc <= w_newdir;
            end
        end
    end

    assign pc           = r_pc;
    assign pcadded      = w_pcadded;
    assign newdir       = w_newdir;
    assign ras_count    = w_ras_count;
    assign ras_top      = w_ras_top;
    assign ret_mismatch = r_mismatch;

endmodule

`default_nettype wire
